delay_sequencer: RTL and testbench

Programmable sequencer that sits directly upstream of the delay counter in the application-specific processor. Fetches 16-bit instructions from an external synchronous program ROM, updates an 8-bit output register, and issues timed waits by pulsing start/delay into the delay counter and waiting for its done. Supports counted loops and jumps so light/pattern programs run without a CPU.

---
 rtl/delay_sequencer.sv | 114 +++++++++++
 tb/tb_delay_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/delay_sequencer.sv
// delay_sequencer: ROM-driven sequencer that sets an output register and issues timed waits
// Ports:
//   clk, reset_n       clock, synchronous active-low reset
//   run                pulse: start program at address 0 from IDLE/HALTED
//   pause              level: holds delay_enable low during a timed wait
//   instr_addr/data    synchronous program ROM (data valid one cycle after address)
//   delay_start/value  start pulse and tick count to the delay counter
//   delay_enable       delay counter enable
//   delay_done         delay counter done
//   data_out           program output register
//   busy, halted, err  status (err is sticky until reset or run)
module delay_sequencer #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              pause,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [15:0]       instr_data,
  output logic              delay_start,
  output logic [7:0]        delay_value,
  output logic              delay_enable,
  input  logic              delay_done,
  output logic [7:0]        data_out,
  output logic              busy,
  output logic              halted,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, DSTART, DWAIT, HALTED} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        loop_q, loop_d, data_q, data_d, dval_q, dval_d;
  logic              err_q, err_d;
  logic [2:0]        op;
  logic [7:0]        imm;
  logic [ADDR_W-1:0] tgt;
  logic              unused_bits;
  assign op          = instr_data[15:13];
  assign imm         = instr_data[7:0];
  assign tgt         = instr_data[ADDR_W-1:0];
  assign unused_bits = ^instr_data[12:8];
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    loop_d  = loop_q;
    data_d  = data_q;
    dval_d  = dval_q;
    err_d   = err_q;
    case (state_q)
      IDLE, HALTED: if (run) begin
        pc_d    = '0;
        err_d   = 1'b0;
        state_d = FETCH;
      end
      FETCH: state_d = EXEC;
      EXEC: begin
        state_d = FETCH;
        pc_d    = pc_q + 1'b1;
        case (op)
          3'd0: begin
            state_d = HALTED;
            pc_d    = pc_q;
          end
          3'd1: data_d = imm;
          3'd2: data_d = data_q + imm;
          3'd3: begin
            dval_d  = imm;
            state_d = DSTART;
          end
          3'd4: pc_d = tgt;
          3'd5: loop_d = imm;
          3'd6: begin
            loop_d = loop_q > 8'd1 ? loop_q - 8'd1 : 8'd0;
            pc_d   = loop_q > 8'd1 ? tgt : pc_q + 1'b1;
          end
          default: begin
            err_d   = 1'b1;
            state_d = HALTED;
            pc_d    = pc_q;
          end
        endcase
      end
      DSTART: state_d = DWAIT;
      DWAIT: state_d = delay_done ? FETCH : DWAIT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      loop_q  <= '0;
      data_q  <= '0;
      dval_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      loop_q  <= loop_d;
      data_q  <= data_d;
      dval_q  <= dval_d;
      err_q   <= err_d;
    end
  end
  assign instr_addr   = pc_q;
  assign delay_start  = state_q == DSTART;
  assign delay_value  = dval_q;
  assign delay_enable = state_q == DWAIT && !pause;
  assign data_out     = data_q;
  assign busy         = state_q != IDLE && state_q != HALTED;
  assign halted       = state_q == HALTED;
  assign err          = err_q;
endmodule

// File: tb/tb_delay_sequencer.sv
// tb_delay_sequencer: directed programs against a ROM and delay-counter model
module tb_delay_sequencer;
  localparam int P = 2;
  logic        clk = 1'b0, reset_n = 1'b0, run = 1'b0, pause = 1'b0, delay_done;
  logic [4:0]  instr_addr, prev_addr = '0;
  logic [15:0] instr_data = '0;
  logic        delay_start, delay_enable, busy, halted, err;
  logic [7:0]  delay_value, data_out, start_val = '0;
  logic [15:0] rom [32];
  int          cnt = 0, pre = 0, starts = 0, cyc = 0, wraps = 0, t0 = 0, s0 = 0, w0 = 0;
  int          checks = 0, errors = 0;
  delay_sequencer #(.ADDR_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .pause(pause),
    .instr_addr(instr_addr), .instr_data(instr_data),
    .delay_start(delay_start), .delay_value(delay_value),
    .delay_enable(delay_enable), .delay_done(delay_done),
    .data_out(data_out), .busy(busy), .halted(halted), .err(err)
  );
  always #10 clk = ~clk;
  assign delay_done = cnt == 0;
  always_ff @(posedge clk) begin
    instr_data <= rom[instr_addr];
    cyc        <= cyc + 1;
    prev_addr  <= instr_addr;
    if (prev_addr == 5'd31 && instr_addr == 5'd0) wraps <= wraps + 1;
    if (delay_start) begin
      starts    <= starts + 1;
      start_val <= delay_value;
    end
    if (!reset_n) begin
      cnt <= 0;
      pre <= 0;
    end else if (delay_start) begin
      cnt <= int'(delay_value);
      pre <= 0;
    end else if (delay_enable) begin
      pre <= pre == P - 1 ? 0 : pre + 1;
      if (pre == P - 1 && cnt != 0) cnt <= cnt - 1;
    end
  end
  function automatic logic [15:0] ins(input logic [2:0] op, input logic [7:0] imm);
    return {op, 5'd0, imm};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic clr();
    foreach (rom[i]) rom[i] = 16'h0000;
  endtask
  task automatic start();
    @(negedge clk);
    run = 1'b1;
    t0  = cyc;
    s0  = starts;
    @(negedge clk);
    run = 1'b0;
  endtask
  task automatic wait_halt(input string tag, input int exp_cyc);
    int n = 0;
    while (!halted && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_halted"}, 32'(halted), 32'd1);
    check({tag, "_cycles"}, 32'(cyc - t0), 32'(exp_cyc));
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask
  task automatic wait_en(input string tag);
    int n = 0;
    while (!delay_enable && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_enable"}, 32'(delay_enable), 32'd1);
  endtask
  initial begin
    clr();
    repeat (2) @(negedge clk);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_start", 32'(delay_start), 32'd0);
    check("rst_dval", 32'(delay_value), 32'd0);
    check("rst_addr", 32'(instr_addr), 32'd0);
    reset_n = 1'b1;
    rom[0] = ins(3'd1, 8'hA5);
    start();
    wait_halt("load", 5);
    check("load_data", 32'(data_out), 32'hA5);
    check("load_pc", 32'(instr_addr), 32'd1);
    clr();
    rom[0] = ins(3'd3, 8'd3);
    rom[1] = ins(3'd1, 8'h01);
    start();
    wait_en("dly");
    check("dly_hold", 32'(data_out), 32'hA5);
    wait_halt("dly", 15);
    check("dly_starts", 32'(starts - s0), 32'd1);
    check("dly_sval", 32'(start_val), 32'd3);
    check("dly_data", 32'(data_out), 32'h01);
    start();
    wait_en("rerun");
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    wait_halt("rerun", 15);
    check("rerun_starts", 32'(starts - s0), 32'd1);
    clr();
    rom[0] = ins(3'd1, 8'h33);
    rom[1] = ins(3'd3, 8'd3);
    rom[2] = ins(3'd1, 8'h01);
    start();
    wait_en("pause");
    pause = 1'b1;
    #1;
    check("pause_en0", 32'(delay_enable), 32'd0);
    repeat (50) @(negedge clk);
    check("pause_en", 32'(delay_enable), 32'd0);
    check("pause_busy", 32'(busy), 32'd1);
    check("pause_dval", 32'(delay_value), 32'd3);
    check("pause_data", 32'(data_out), 32'h33);
    pause = 1'b0;
    wait_halt("pause", 67);
    check("pause_done", 32'(data_out), 32'h01);
    clr();
    rom[0] = ins(3'd1, 8'h44);
    rom[1] = ins(3'd2, 8'h01);
    pause = 1'b1;
    start();
    wait_halt("pausex", 7);
    check("pausex_data", 32'(data_out), 32'h45);
    pause = 1'b0;
    clr();
    rom[0] = ins(3'd3, 8'd0);
    start();
    wait_halt("d0", 7);
    check("d0_starts", 32'(starts - s0), 32'd1);
    check("d0_sval", 32'(start_val), 32'd0);
    clr();
    rom[0] = ins(3'd1, 8'h00);
    rom[1] = ins(3'd5, 8'd4);
    rom[2] = ins(3'd2, 8'h10);
    rom[3] = ins(3'd6, 8'd2);
    start();
    wait_halt("loop4", 23);
    check("loop4_data", 32'(data_out), 32'h40);
    clr();
    rom[0] = ins(3'd1, 8'h00);
    rom[1] = ins(3'd2, 8'h01);
    rom[2] = ins(3'd6, 8'd1);
    start();
    wait_halt("lcnt0", 9);
    check("lcnt0_data", 32'(data_out), 32'h01);
    clr();
    rom[0] = ins(3'd1, 8'h00);
    rom[1] = ins(3'd5, 8'd0);
    rom[2] = ins(3'd2, 8'h10);
    rom[3] = ins(3'd6, 8'd2);
    start();
    wait_halt("loop0", 11);
    check("loop0_data", 32'(data_out), 32'h10);
    clr();
    rom[0] = ins(3'd1, 8'hF0);
    rom[1] = ins(3'd2, 8'h20);
    start();
    wait_halt("addw", 7);
    check("addw_data", 32'(data_out), 32'h10);
    clr();
    rom[0]  = ins(3'd6, 8'd3);
    rom[1]  = ins(3'd5, 8'd2);
    rom[2]  = ins(3'd4, 8'd31);
    rom[31] = ins(3'd1, 8'h5A);
    w0 = wraps;
    start();
    wait_halt("pcw", 13);
    check("pcw_data", 32'(data_out), 32'h5A);
    check("pcw_pc", 32'(instr_addr), 32'd3);
    check("pcw_wraps", 32'(wraps - w0), 32'd1);
    clr();
    rom[0] = ins(3'd1, 8'h09);
    rom[1] = 16'hE000;
    start();
    wait_halt("ill", 5);
    check("ill_err", 32'(err), 32'd1);
    check("ill_data", 32'(data_out), 32'h09);
    clr();
    start();
    check("ill_clr", 32'(err), 32'd0);
    wait_halt("halt", 3);
    clr();
    rom[0] = ins(3'd3, 8'd3);
    rom[1] = ins(3'd1, 8'h01);
    start();
    wait_en("rst");
    reset_n = 1'b0;
    @(negedge clk);
    check("rstw_data", 32'(data_out), 32'h0);
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_halted", 32'(halted), 32'd0);
    check("rstw_dval", 32'(delay_value), 32'd0);
    check("rstw_en", 32'(delay_enable), 32'd0);
    check("rstw_addr", 32'(instr_addr), 32'd0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rstw_idle", 32'(busy), 32'd0);
    check("rstw_starts", 32'(starts - s0), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
